// File: rtl/bta_pkg.sv
// Shared definitions for the binary-tree pipelined adder.
//   clog2  : ceiling log2 used to derive the number of tree levels
//   op_lo  : low bit index of element k in a packed vector of w-bit elements
//   DEF_*  : default operand count, operand width and tag width
package bta_pkg;

  localparam int DEF_NUM_OPS = 8;
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TAG_W   = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int op_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/bta_level.sv
// One level of the adder tree: PAIRS registered pairwise adders, each adding
// two adjacent IN_W-bit values into an (IN_W+1)-bit result, plus the valid
// bit and tag that travel with the data.
// Optional feature macro: BTA_SIGNED_EN (sign-extend addends; default zero-extend).
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears valid, data and tag
//   en       : level enable; all state holds when low
//   in_vld   : incoming data is a real operand set (low = bubble)
//   in_data  : 2*PAIRS packed IN_W-bit values
//   in_tag   : tag of the incoming operand set
//   out_vld  : registered valid
//   out_data : PAIRS packed (IN_W+1)-bit sums
//   out_tag  : registered tag
module bta_level
  import bta_pkg::*;
#(
  parameter int PAIRS = 4,
  parameter int IN_W  = DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        in_vld,
  input  logic [2*PAIRS*IN_W-1:0]     in_data,
  input  logic [TAG_W-1:0]            in_tag,
  output logic                        out_vld,
  output logic [PAIRS*(IN_W+1)-1:0]   out_data,
  output logic [TAG_W-1:0]            out_tag
);

  localparam int SUM_W = IN_W + 1;

  // Widen an addend by one bit so the pairwise sum can never overflow.
  function automatic logic [SUM_W-1:0] ext(input logic [IN_W-1:0] v);
`ifdef BTA_SIGNED_EN
    return {v[IN_W-1], v};
`else
    return {1'b0, v};
`endif
  endfunction

  logic [PAIRS*SUM_W-1:0] w_sum;
  logic                   r_vld;
  logic [PAIRS*SUM_W-1:0] r_data;
  logic [TAG_W-1:0]       r_tag;

  always_comb begin
    w_sum = '0;
    for (int p = 0; p < PAIRS; p++) begin
      w_sum[op_lo(p, SUM_W) +: SUM_W] = ext(in_data[op_lo(2*p, IN_W) +: IN_W])
                                      + ext(in_data[op_lo(2*p+1, IN_W) +: IN_W]);
    end
  end

  // Level register bank
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_tag  <= '0;
    end else if (en) begin
      r_vld  <= in_vld;
      r_data <= w_sum;
      r_tag  <= in_tag;
    end
  end

  assign out_vld  = r_vld;
  assign out_data = r_data;
  assign out_tag  = r_tag;

endmodule

// File: rtl/bta_pipe_adder.sv
// Pipelined binary-tree adder: sums NUM_OPS operands of WIDTH bits into a
// full-precision OUT_W = WIDTH + log2(NUM_OPS) result, one tree level per
// pipeline stage, with a tag carried alongside each operand set and a
// valid/ready handshake on both sides.
// Optional feature macro: BTA_SIGNED_EN (two's complement operands and sum).
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, flushes every in-flight set
//   in_valid  : operand set on ops/in_tag is valid
//   in_ready  : operand set is accepted this cycle
//   ops       : packed operands, operand k at ops[k*WIDTH +: WIDTH]
//   in_tag    : tag travelling with the operand set
//   out_valid : sum/out_tag hold a result
//   out_ready : downstream takes the result this cycle
//   sum       : sum of all operands, OUT_W bits
//   out_tag   : tag of the operand set that produced sum
module bta_pipe_adder
  import bta_pkg::*;
#(
  parameter int NUM_OPS = DEF_NUM_OPS,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_OPS*WIDTH-1:0]          ops,
  input  logic [TAG_W-1:0]                  in_tag,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH+clog2(NUM_OPS)-1:0]   sum,
  output logic [TAG_W-1:0]                  out_tag
);

  localparam int LEVELS = clog2(NUM_OPS);
  localparam int OUT_W  = WIDTH + LEVELS;

  // The whole pipe moves as one: it stalls only when a result is waiting
  // and downstream refuses it, so no level ever holds two sets.
  logic w_advance;
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int IW    = WIDTH + l;
    localparam int PAIRS = NUM_OPS >> (l + 1);

    logic [2*PAIRS*IW-1:0]     w_in;
    logic                      w_in_vld;
    logic [TAG_W-1:0]          w_in_tag;
    logic [PAIRS*(IW+1)-1:0]   w_out;
    logic                      w_out_vld;
    logic [TAG_W-1:0]          w_out_tag;

    if (l == 0) begin : g_first
      assign w_in     = ops;
      assign w_in_vld = in_valid;
      assign w_in_tag = in_tag;
    end else begin : g_next
      assign w_in     = g_lvl[l-1].w_out;
      assign w_in_vld = g_lvl[l-1].w_out_vld;
      assign w_in_tag = g_lvl[l-1].w_out_tag;
    end

    bta_level #(
      .PAIRS (PAIRS),
      .IN_W  (IW),
      .TAG_W (TAG_W)
    ) u_level (
      .clk      (clk),
      .rst      (rst),
      .en       (w_advance),
      .in_vld   (w_in_vld),
      .in_data  (w_in),
      .in_tag   (w_in_tag),
      .out_vld  (w_out_vld),
      .out_data (w_out),
      .out_tag  (w_out_tag)
    );
  end

  // The last level holds a single OUT_W-bit value: the complete sum.
  assign out_valid = g_lvl[LEVELS-1].w_out_vld;
  assign sum       = g_lvl[LEVELS-1].w_out[OUT_W-1:0];
  assign out_tag   = g_lvl[LEVELS-1].w_out_tag;

endmodule

// File: tb/tb_bta_pipe_adder.sv
module tb_bta_pipe_adder;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int TW = 4;
  localparam int OW = 19;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N*W-1:0]  ops;
  logic [TW-1:0]   in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [OW-1:0]   sum;
  logic [TW-1:0]   out_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bta_pipe_adder #(.NUM_OPS(N), .WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ops       (ops),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .out_tag   (out_tag)
  );

  // Straight linear sum of all operands, truncated to the output width.
  function automatic logic [OW-1:0] ref_sum(input logic [N*W-1:0] v);
    int s;
    logic [31:0] t;
    s = 0;
    for (int k = 0; k < N; k++) begin
`ifdef BTA_SIGNED_EN
      s += int'($signed(v[k*W +: W]));
`else
      s += int'(v[k*W +: W]);
`endif
    end
    t = s;
    return t[OW-1:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ops = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (sum !== '0) begin bad++; $display("FAIL reset_sum got=%h want=0", sum); end
    total++; if (out_tag !== '0) begin bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_latency();
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_tag = 4'h5;
    for (int k = 0; k < N; k++) ops[k*W +: W] = 16'(k + 1);
    @(posedge clk); #1 in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_cycle1 out_valid got=%0b want=0", out_valid); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_cycle2 out_valid got=%0b want=0", out_valid); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_cycle3 out_valid got=%0b want=1", out_valid); end
    total++; if (sum !== 19'h00024) begin bad++; $display("FAIL lat_sum got=%h want=00024", sum); end
    total++; if (out_tag !== 4'h5) begin bad++; $display("FAIL lat_tag got=%h want=5", out_tag); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_bubble out_valid got=%0b want=0", out_valid); end
  endtask

  task automatic test_extremes();
    logic [OW-1:0] exp;
    bit seen;
    for (int v = 0; v < 2; v++) begin
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1; in_tag = 4'(v + 2);
      if (v == 0) begin
        for (int k = 0; k < N; k++) ops[k*W +: W] = 16'hFFFF;
        exp = 19'h7FFF8;
      end else begin
        for (int k = 0; k < N; k++) ops[k*W +: W] = (k < 4) ? 16'hFFFF : 16'h0001;
`ifdef BTA_SIGNED_EN
        exp = 19'h00000;
`else
        exp = 19'h40000;
`endif
      end
      @(posedge clk); #1 in_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (out_valid === 1'b1) begin
          seen = 1'b1;
          total++;
          if (sum !== exp || out_tag !== 4'(v + 2)) begin
            bad++; $display("FAIL extreme_%0d got sum=%h tag=%h want sum=%h tag=%h", v, sum, out_tag, exp, 4'(v + 2));
          end
        end
      end
      if (!seen) begin total++; bad++; $display("FAIL extreme_%0d_timeout got no out_valid want result", v); end
    end
  endtask

  task automatic test_back_to_back();
    int sent, got;
    bit hold;
    logic [OW-1:0] hs;
    logic [TW-1:0] ht;
    sent = 0; got = 0; hold = 1'b0; hs = '0; ht = '0;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      @(posedge clk); #1;
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (sent < 10);
      in_tag    = 4'(sent);
      for (int k = 0; k < N; k++) ops[k*W +: W] = 16'(sent + k);
      @(negedge clk);
      if (hold) begin
        total++;
        if (out_valid !== 1'b1 || sum !== hs || out_tag !== ht) begin
          bad++; $display("FAIL b2b_stable got v=%0b sum=%h tag=%h want v=1 sum=%h tag=%h", out_valid, sum, out_tag, hs, ht);
        end
      end
      total++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        bad++; $display("FAIL b2b_in_ready got=%0b want=%0b", in_ready, !(out_valid && !out_ready));
      end
      if (out_valid && out_ready) begin
        total++;
        if (sum !== OW'(8*got + 28) || out_tag !== 4'(got)) begin
          bad++; $display("FAIL b2b_result got sum=%h tag=%h want sum=%h tag=%h", sum, out_tag, OW'(8*got + 28), 4'(got));
        end
        got++;
      end
      hold = out_valid && !out_ready;
      hs = sum; ht = out_tag;
      if (in_valid && in_ready) sent++;
    end
    total++; if (got != 10) begin bad++; $display("FAIL b2b_count got=%0d want=10", got); end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_midflight();
    bit leak;
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_tag = 4'(8 + i);
      for (int k = 0; k < N; k++) ops[k*W +: W] = 16'(100 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    leak = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) leak = 1'b1;
    end
    total++; if (leak) begin bad++; $display("FAIL midreset_leak got out_valid=1 want 0"); end
    @(posedge clk); #1;
    in_valid = 1'b1; in_tag = 4'hA;
    for (int k = 0; k < N; k++) ops[k*W +: W] = 16'h0002;
    @(posedge clk); #1 in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_c1 got=%0b want=0", out_valid); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_c2 got=%0b want=0", out_valid); end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || sum !== 19'h00010 || out_tag !== 4'hA) begin
      bad++; $display("FAIL midreset_result got v=%0b sum=%h tag=%h want v=1 sum=00010 tag=a", out_valid, sum, out_tag);
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] exp_q[$];
    logic [TW-1:0] tag_q[$];
    int sent, got;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 5000 && got < 300; cyc++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < 300) && ($urandom_range(0, 3) != 0);
      in_tag    = 4'($urandom);
      for (int k = 0; k < N; k++) ops[k*W +: W] = 16'($urandom);
      @(negedge clk);
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_extra got sum=%h tag=%h want none", sum, out_tag);
        end else begin
          if (sum !== exp_q[0] || out_tag !== tag_q[0]) begin
            bad++; $display("FAIL rand_result got sum=%h tag=%h want sum=%h tag=%h", sum, out_tag, exp_q[0], tag_q[0]);
          end
          void'(exp_q.pop_front());
          void'(tag_q.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_sum(ops));
        tag_q.push_back(in_tag);
        sent++;
      end
    end
    total++; if (got != 300) begin bad++; $display("FAIL rand_count got=%0d want=300", got); end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_extremes();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bta_pipe_adder.md
BTA_PIPE_ADDER -- requirements
Module: bta_pipe_adder

Interface
REQ-001 SHALL have parameter NUM_OPS, default 8, number of operands; power of two, >= 2.
REQ-002 SHALL have parameter WIDTH, default 16, bit width of each operand.
REQ-003 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each operand set.
REQ-004 SHALL define LEVELS = log2(NUM_OPS) and OUT_W = WIDTH + LEVELS as derived localparams.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  operand set on ops/in_tag is valid.
REQ-008 in_ready  output  1  block accepts the operand set this cycle.
REQ-009 ops  input  NUM_OPS*WIDTH  packed operands; operand k is ops[k*WIDTH +: WIDTH].
REQ-010 in_tag  input  TAG_W  tag travelling with the operand set.
REQ-011 out_valid  output  1  sum/out_tag hold a valid result.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.
REQ-013 sum  output  OUT_W  sum of all NUM_OPS operands, full precision.
REQ-014 out_tag  output  TAG_W  tag of the operand set that produced sum.

Function
REQ-015 SHALL compute sum as a binary tree: level l (0..LEVELS-1) adds adjacent pairs of level-l values of width WIDTH+l into WIDTH+l+1-bit results, with one pipeline register bank per level.
REQ-016 SHALL use carry-in 0 for every adder; sum SHALL never overflow OUT_W.
REQ-017 SHALL define advance = !out_valid || out_ready; in_ready SHALL equal advance.
REQ-018 SHALL accept an operand set when in_valid && in_ready; latency from acceptance to out_valid is exactly LEVELS cycles when out_ready is held 1.
REQ-019 SHALL sustain throughput of one result per cycle while out_ready = 1.
REQ-020 SHALL freeze all level registers, valid bits and tags when advance = 0; sum, out_tag, out_valid SHALL hold stable until out_ready = 1.
REQ-021 SHALL advance a per-level valid bit with data; an empty input cycle (in_valid = 0 with advance = 1) SHALL insert a bubble, not a duplicate result.
REQ-022 SHALL deliver results in acceptance order, each with its own in_tag.
REQ-023 SHALL not drop or duplicate any accepted operand set under any out_ready pattern.

Reset
REQ-024 SHALL, with rst = 1 at a rising edge, clear all valid bits, level registers, sum and out_tag to 0; out_valid = 0 the following cycle.
REQ-025 SHALL discard all in-flight operand sets on reset mid-operation; no result of a pre-reset set SHALL appear afterwards.
REQ-026 SHALL drive in_ready = 1 the cycle after reset releases.

Configuration
REQ-027 SHALL, with macro BTA_SIGNED_EN defined, treat operands as two's complement and sign-extend each addend by one bit per level; sum is signed OUT_W.
REQ-028 SHALL, without BTA_SIGNED_EN, treat operands as unsigned and zero-extend; sum is unsigned OUT_W.

Structure
REQ-029 SHALL place a clog2 function, default NUM_OPS/WIDTH/TAG_W constants and the packed-operand index helper in shared package bta_pkg.
REQ-030 SHALL implement one tree level as sub-module bta_level (parameters: pair count, input width; registered pairwise adders with valid, tag and enable), instantiated LEVELS times by generate.

Verification
REQ-031 NUM_OPS=8, WIDTH=16, ops = 1..8, out_ready=1 -> out_valid rises exactly 3 cycles after acceptance, sum = 0x00024.
REQ-032 All operands 0xFFFF, unsigned build -> sum = 0x7FFF8 (19 bits).
REQ-033 Operands 4x 0xFFFF + 4x 0x0001: unsigned build -> sum = 0x40000; BTA_SIGNED_EN build -> sum = 0x00000.
REQ-034 Back-to-back 10 sets with tags 0..9, out_ready toggling 1,0,0,1 repeating -> results in tag order 0..9, values correct, sum/out_tag stable while out_ready = 0, in_ready = 0 exactly when out_valid && !out_ready.
REQ-035 Accept 3 sets, assert rst for 1 cycle before any result leaves -> out_valid stays 0 until a new post-reset set completes 3 cycles later.
REQ-036 Random NUM_OPS in {2,4,16}, WIDTH in {4,16,32}, random valid/ready -> scoreboard match against reference model, zero mismatches over 10000 sets.
